// File: rtl/count_arbiter_pkg.sv
// Shared types and constants for the count_arbiter block: FSM state encoding
// and the number of requesters.
package count_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/count_core.sv
// Shared up/down counter with synchronous clear and step enable.
// Optional sticky wrap flag when WRAP_FLAG_EN is defined.
module count_core #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic             up,
    output logic [WIDTH-1:0] cnt
`ifdef WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= up ? (cnt + ONE) : (cnt - ONE);
        end
    end

`ifdef WRAP_FLAG_EN
    // A step crosses the modulo boundary when leaving all-ones upward or zero downward.
    logic crossing;
    assign crossing = step && ((up && (&cnt)) || (!up && (cnt == '0)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else if (clear) begin
            wrap <= 1'b0;
        end else if (crossing) begin
            wrap <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter granting bursts of up/down steps on a shared counter.
// Optional wrap flag output when WRAP_FLAG_EN is defined.
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               dir0,
    input  logic               dir1,
    input  logic [LEN_W-1:0]   len0,
    input  logic [LEN_W-1:0]   len1,
    input  logic               clear,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic [WIDTH-1:0]   cnt,
`ifdef WRAP_FLAG_EN
    output logic               wrap,
`endif
    output state_e             dbg_state
);

    // Handshake: req is level-sampled only in IDLE; gnt and done are single-cycle
    // pulses, and busy stays high from the cycle after the grant until IDLE returns.

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e               state, state_n;
    logic [NUM_REQ-1:0]   gnt_n, done_n;
    logic [LEN_W-1:0]     rem, rem_n;
    logic                 ptr, ptr_n;
    logic                 owner, owner_n;
    logic                 dir_q, dir_n;
    logic                 win;
    logic [LEN_W-1:0]     len_sel;
    logic                 step;
    logic                 clr_eff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            rem   <= '0;
            ptr   <= 1'b0;
            owner <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            done  <= done_n;
            rem   <= rem_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            dir_q <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = '0;
        done_n  = '0;
        rem_n   = rem;
        ptr_n   = ptr;
        owner_n = owner;
        dir_n   = dir_q;
        win     = 1'b0;
        len_sel = '0;
        step    = 1'b0;
        clr_eff = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    clr_eff = 1'b1;
                end else if (|req) begin
                    // With both requesting the pointer decides; it then moves to the loser.
                    win     = (req == 2'b11) ? ptr : req[1];
                    ptr_n   = ~win;
                    owner_n = win;
                    dir_n   = win ? dir1 : dir0;
                    len_sel = win ? len1 : len0;
                    rem_n   = len_sel;
                    gnt_n   = win ? 2'b10 : 2'b01;
                    if (len_sel == '0) begin
                        state_n = DONE;
                        done_n  = gnt_n;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                step  = 1'b1;
                rem_n = rem - LEN_ONE;
                if (rem == LEN_ONE) begin
                    state_n = DONE;
                    done_n  = owner ? 2'b10 : 2'b01;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clear (clr_eff),
        .step  (step),
        .up    (dir_q),
        .cnt   (cnt)
`ifdef WRAP_FLAG_EN
        ,
        .wrap  (wrap)
`endif
    );

endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 128, counter datapath width in bits.
REQ-002 SHALL have parameter LEN_W, default 8, burst-length field width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  2  per-requester burst request (index 0/1).
REQ-006 SHALL have port dir0, dir1  input  1 each  burst direction per requester; 1 = up, 0 = down.
REQ-007 SHALL have port len0, len1  input  LEN_W each  burst step count per requester.
REQ-008 SHALL have port clear  input  1  synchronous counter clear request.
REQ-009 SHALL have port gnt  output  2  one-hot grant pulse.
REQ-010 SHALL have port done  output  2  one-hot burst-complete pulse.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-012 SHALL have port cnt  output  WIDTH  current shared counter value.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 In IDLE, SHALL sample req on every edge; if any bit set and clear low, SHALL pick a winner, latch its dir and len, and move to RUN (len != 0) or DONE (len == 0).
REQ-015 Arbitration SHALL be round-robin: when both request, the requester indicated by the priority pointer wins; the pointer SHALL point to the non-winner after each grant.
REQ-016 gnt[winner] SHALL be high for exactly the one cycle following the grant edge; gnt SHALL be 0 at all other times.
REQ-017 In RUN, on each edge cnt SHALL step by +1 (dir = 1) or -1 (dir = 0) and the remaining count SHALL decrement; the edge performing the L-th step SHALL move the FSM to DONE.
REQ-018 For len = L > 0 granted at edge k: steps at edges k+1..k+L; done[winner] high during the cycle after edge k+L; IDLE entered at edge k+L+1.
REQ-019 For len = 0: cnt unchanged; gnt and done both high in the cycle after the grant edge; IDLE at the next edge.
REQ-020 cnt arithmetic SHALL be modulo 2^WIDTH (all-ones + 1 = 0; 0 - 1 = all-ones).
REQ-021 req, dir and len changes during RUN/DONE SHALL be ignored; a started burst always completes.
REQ-022 clear SHALL take effect only in IDLE: cnt <= 0 at that edge, no grant issued that edge; requests pending are served on a later edge.
REQ-023 clear asserted in RUN or DONE SHALL be ignored.

Reset
REQ-024 Reset low SHALL immediately force: state IDLE, cnt 0, gnt 0, done 0, busy 0, remaining count 0, priority pointer to requester 0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no done pulse.

Configuration
REQ-026 With WRAP_FLAG_EN defined, SHALL provide output wrap (1 bit), a sticky flag set on any step crossing between all-ones and 0 in either direction, cleared by reset or an effective clear.
REQ-027 Without WRAP_FLAG_EN, the wrap port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the requester-count constant (2).
REQ-029 The counter datapath SHALL be a sub-module count_core (WIDTH-bit, synchronous clear, step enable, direction input, async active-low reset); count_arbiter holds FSM, pointer and remaining count.

Verification
REQ-030 Reset, req = 01, dir0 = 1, len0 = 3 -> gnt = 01 one cycle, cnt 0->1->2->3 on three successive edges, done = 01 one cycle after the third step, busy falls next cycle.
REQ-031 req = 11 held from reset, len0 = len1 = 1, dir0 = 1, dir1 = 0 -> grants alternate 01, 10, 01, ...; cnt toggles 0,1,0,1.
REQ-032 cnt = 0, req = 10, dir1 = 0, len1 = 2 -> cnt = all-ones then all-ones - 1; with WRAP_FLAG_EN wrap = 1 after the first step and stays 1.
REQ-033 req = 01, len0 = 0 -> gnt = 01 and done = 01 in the same cycle, cnt unchanged, busy high exactly one cycle.
REQ-034 clear and req = 01 both high in IDLE with cnt = 5 -> cnt = 0, no gnt that edge, gnt = 01 on the following edge; clear during RUN -> ignored.
REQ-035 Reset pulsed low mid-RUN (len0 = 200, after 50 steps) -> cnt = 0, busy = 0 immediately, no done pulse.
